// File: rtl/instr_image_encoder_pkg.sv
// Shared MIPS instruction constants: request kind codes, opcodes and function codes.
// The control decoder imports the same constants so encoder and decoder cannot drift apart.
package instr_image_encoder_pkg;

    typedef enum logic [3:0] {
        KIND_NOP  = 4'd0,
        KIND_ADDU = 4'd1,
        KIND_SUBU = 4'd2,
        KIND_JR   = 4'd3,
        KIND_SLL  = 4'd4,
        KIND_ORI  = 4'd5,
        KIND_LW   = 4'd6,
        KIND_SW   = 4'd7,
        KIND_BEQ  = 4'd8,
        KIND_LUI  = 4'd9,
        KIND_JAL  = 4'd10,
        KIND_J    = 4'd11
    } kind_e;

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_ORI     = 6'b001101;
    localparam logic [5:0] OP_LW      = 6'b100011;
    localparam logic [5:0] OP_SW      = 6'b101011;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_LUI     = 6'b001111;
    localparam logic [5:0] OP_JAL     = 6'b000011;
    localparam logic [5:0] OP_J       = 6'b000010;

    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_JR   = 6'b001000;
    localparam logic [5:0] FN_SLL  = 6'b000000;

endpackage

// File: rtl/instr_fifo.sv
// Synchronous FIFO holding encoded instruction words until the IM write port accepts them.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module instr_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      occupancy
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_q, rd_ptr_q;
    logic             push_en, pop_en;

    assign occupancy = wr_ptr_q - rd_ptr_q;
    assign full      = (occupancy == (AW + 1)'(DEPTH));
    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign push_en   = push & ~full;
    assign pop_en    = pop & ~empty;
    assign rdata     = mem[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_en) begin
                wr_ptr_q <= wr_ptr_q + (AW + 1)'(1);
            end
            if (pop_en) begin
                rd_ptr_q <= rd_ptr_q + (AW + 1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_en) begin
            mem[wr_ptr_q[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/instr_image_encoder.sv
// Encodes symbolic MIPS instruction requests and streams the words into instruction memory
// at consecutive word addresses starting from BASE_ADDR.
module instr_image_encoder
    import instr_image_encoder_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned IM_AW      = 10,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_3000
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [3:0]     in_kind,
    input  logic [4:0]     in_rs,
    input  logic [4:0]     in_rt,
    input  logic [4:0]     in_rd,
    input  logic [4:0]     in_shamt,
    input  logic [15:0]    in_imm,
    input  logic [25:0]    in_target,
    input  logic           flush,
    output logic           im_we,
    output logic [31:0]    im_addr,
    output logic [31:0]    im_wdata,
    input  logic           im_ack,
    output logic [IM_AW:0] count,
    output logic           full,
    output logic           illegal
);

    localparam int unsigned    OCC_W    = $clog2(FIFO_DEPTH) + 1;
    localparam logic [IM_AW:0] CAPACITY = {1'b1, {IM_AW{1'b0}}};

    function automatic logic [31:0] encode(
        input logic [3:0]  kind,
        input logic [4:0]  rs,
        input logic [4:0]  rt,
        input logic [4:0]  rd,
        input logic [4:0]  shamt,
        input logic [15:0] imm,
        input logic [25:0] target
    );
        logic [31:0] word;
        word = 32'h0;
        case (kind)
            KIND_NOP:  word = 32'h0;
            KIND_ADDU: word = {OP_SPECIAL, rs, rt, rd, 5'b0, FN_ADDU};
            KIND_SUBU: word = {OP_SPECIAL, rs, rt, rd, 5'b0, FN_SUBU};
            KIND_JR:   word = {OP_SPECIAL, rs, 15'b0, FN_JR};
            KIND_SLL:  word = {OP_SPECIAL, 5'b0, rt, rd, shamt, FN_SLL};
            KIND_ORI:  word = {OP_ORI, rs, rt, imm};
            KIND_LW:   word = {OP_LW, rs, rt, imm};
            KIND_SW:   word = {OP_SW, rs, rt, imm};
            KIND_BEQ:  word = {OP_BEQ, rs, rt, imm};
            KIND_LUI:  word = {OP_LUI, 5'b0, rt, imm};
            KIND_JAL:  word = {OP_JAL, target};
            KIND_J:    word = {OP_J, target};
            default:   word = 32'h0;
        endcase
        return word;
    endfunction

    logic [IM_AW:0]   count_q, count_d;
    logic             illegal_q, illegal_d;
    logic             fifo_full, fifo_empty;
    logic [OCC_W-1:0] occupancy;
    logic [31:0]      head;
    logic [IM_AW+1:0] in_flight;
    logic             accept, legal, push, pop;

    // Accept limit includes buffered words so the committed count can never pass capacity.
    assign in_flight = {1'b0, count_q} + (IM_AW + 2)'(occupancy);
    assign in_ready  = reset & ~flush & ~fifo_full & (in_flight < {1'b0, CAPACITY});
    assign accept    = in_valid & in_ready;
    assign legal     = (in_kind <= KIND_J);
    assign push      = accept & legal;
    assign pop       = im_we & im_ack & ~flush;

    assign im_we    = ~fifo_empty;
    assign im_wdata = fifo_empty ? 32'h0 : head;
    assign im_addr  = BASE_ADDR + 32'({count_q, 2'b00});
    assign count    = count_q;
    assign full     = (count_q == CAPACITY);
    assign illegal  = illegal_q;

    always_comb begin
        count_d   = count_q;
        illegal_d = illegal_q;
        if (flush) begin
            count_d   = '0;
            illegal_d = 1'b0;
        end else begin
            if (pop) begin
                count_d = count_q + (IM_AW + 1)'(1);
            end
            if (accept && !legal) begin
                illegal_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q   <= '0;
            illegal_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            illegal_q <= illegal_d;
        end
    end

    instr_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .clear     (flush),
        .push      (push),
        .pop       (pop),
        .wdata     (encode(in_kind, in_rs, in_rt, in_rd, in_shamt, in_imm, in_target)),
        .rdata     (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .occupancy (occupancy)
    );

endmodule

// File: tb/tb_instr_image_encoder.sv
// Bench for instr_image_encoder: queue-based reference model checked every cycle, plus
// directed image checks and a small-capacity instance for the full/flush behaviour.
module tb_instr_image_encoder;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned CAP   = 1024;
    localparam logic [31:0] BASE  = 32'h0000_3000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, in_valid, flush, im_ack;
    logic [3:0]  in_kind;
    logic [4:0]  in_rs, in_rt, in_rd, in_shamt;
    logic [15:0] in_imm;
    logic [25:0] in_target;
    logic        in_ready, im_we, full, illegal;
    logic [31:0] im_addr, im_wdata;
    logic [10:0] count;

    logic        s_reset, s_valid, s_flush, s_ack;
    logic [3:0]  s_kind;
    logic        s_ready, s_we, s_full, s_illegal;
    logic [31:0] s_addr, s_wdata;
    logic [2:0]  s_count;

    instr_image_encoder #(.FIFO_DEPTH(4), .IM_AW(10), .BASE_ADDR(32'h0000_3000)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_kind(in_kind), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
        .in_imm(in_imm), .in_target(in_target), .flush(flush), .im_we(im_we),
        .im_addr(im_addr), .im_wdata(im_wdata), .im_ack(im_ack), .count(count),
        .full(full), .illegal(illegal)
    );

    instr_image_encoder #(.FIFO_DEPTH(4), .IM_AW(2), .BASE_ADDR(32'h0000_3000)) dut_small (
        .clk(clk), .reset(s_reset), .in_valid(s_valid), .in_ready(s_ready),
        .in_kind(s_kind), .in_rs(5'd0), .in_rt(5'd0), .in_rd(5'd0), .in_shamt(5'd0),
        .in_imm(16'd0), .in_target(26'd0), .flush(s_flush), .im_we(s_we),
        .im_addr(s_addr), .im_wdata(s_wdata), .im_ack(s_ack), .count(s_count),
        .full(s_full), .illegal(s_illegal)
    );

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;

    int          total = 0;
    int          bad = 0;
    int unsigned mq[$];
    int unsigned mcnt = 0;
    bit          mill = 1'b0;
    bit          chk_en = 1'b0;
    wr_t         wlog[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Word layout from the instruction-set tables, built with plain shifts of field values.
    function automatic void ref_word(input int unsigned k, input int unsigned rs,
                                     input int unsigned rt, input int unsigned rd,
                                     input int unsigned sh, input int unsigned imm,
                                     input int unsigned tgt, output bit ok,
                                     output int unsigned w);
        ok = 1'b1;
        case (k)
            0:  w = 0;
            1:  w = (rs << 21) | (rt << 16) | (rd << 11) | 33;
            2:  w = (rs << 21) | (rt << 16) | (rd << 11) | 35;
            3:  w = (rs << 21) | 8;
            4:  w = (rt << 16) | (rd << 11) | (sh << 6);
            5:  w = (13 << 26) | (rs << 21) | (rt << 16) | imm;
            6:  w = (35 << 26) | (rs << 21) | (rt << 16) | imm;
            7:  w = (43 << 26) | (rs << 21) | (rt << 16) | imm;
            8:  w = (4 << 26) | (rs << 21) | (rt << 16) | imm;
            9:  w = (15 << 26) | (rt << 16) | imm;
            10: w = (3 << 26) | tgt;
            11: w = (2 << 26) | tgt;
            default: begin
                ok = 1'b0;
                w  = 0;
            end
        endcase
    endfunction

    task automatic tick(output bit acc);
        bit          rdy, we, wr, ok;
        int unsigned w;
        @(negedge clk);
        rdy = reset && !flush && (mq.size() < DEPTH) && (mcnt + mq.size() < CAP);
        we  = (mq.size() != 0);
        if (chk_en) begin
            check("in_ready", 32'(in_ready), 32'(rdy));
            check("im_we", 32'(im_we), 32'(we));
            check("im_addr", im_addr, BASE + 4 * mcnt);
            check("im_wdata", im_wdata, we ? mq[0] : 32'h0);
            check("count", 32'(count), mcnt);
            check("full", 32'(full), 32'(mcnt == CAP));
            check("illegal", 32'(illegal), 32'(mill));
        end
        if (reset && !flush && im_we && im_ack) wlog.push_back({im_addr, im_wdata});
        acc = in_valid && rdy;
        wr  = we && im_ack && !flush;
        ref_word(32'(in_kind), 32'(in_rs), 32'(in_rt), 32'(in_rd), 32'(in_shamt),
                 32'(in_imm), 32'(in_target), ok, w);
        @(posedge clk);
        if (!reset || flush) begin
            mq.delete();
            mcnt = 0;
            mill = 1'b0;
        end else begin
            if (wr) begin
                void'(mq.pop_front());
                mcnt++;
            end
            if (acc) begin
                if (ok) mq.push_back(w);
                else mill = 1'b1;
            end
        end
        #1;
    endtask

    task automatic idle(input int n);
        bit a;
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) tick(a);
    endtask

    task automatic send(input logic [3:0] k, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [4:0] sh, input logic [15:0] imm,
                        input logic [25:0] tgt);
        bit acc;
        acc = 1'b0;
        in_valid = 1'b1;
        in_kind = k; in_rs = rs; in_rt = rt; in_rd = rd; in_shamt = sh;
        in_imm = imm; in_target = tgt;
        for (int i = 0; i < 50 && !acc; i++) tick(acc);
        if (!acc) check("accept_timeout", 32'(acc), 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        bit a;
        reset = 1'b0; in_valid = 1'b0; flush = 1'b0;
        tick(a);
        reset = 1'b1;
        wlog.delete();
    endtask

    task automatic check_wr(input string tag, input int idx, input logic [31:0] a,
                            input logic [31:0] d);
        if (idx < wlog.size()) begin
            check({tag, "_addr"}, wlog[idx].a, a);
            check({tag, "_data"}, wlog[idx].d, d);
        end else begin
            check({tag, "_missing"}, 32'(wlog.size()), 32'(idx + 1));
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired before test completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        int sacc;
        logic [31:0] swr[$];

        reset = 1'b0; in_valid = 1'b0; flush = 1'b0; im_ack = 1'b0;
        in_kind = '0; in_rs = '0; in_rt = '0; in_rd = '0; in_shamt = '0;
        in_imm = '0; in_target = '0;
        s_reset = 1'b0; s_valid = 1'b0; s_flush = 1'b0; s_ack = 1'b0; s_kind = 4'd0;
        #1;
        do_reset();
        chk_en = 1'b1;
        do_reset();

        // Single ADDU.
        im_ack = 1'b1;
        send(4'd1, 5'd1, 5'd2, 5'd3, 5'd0, 16'd0, 26'd0);
        idle(3);
        check("addu_nwr", 32'(wlog.size()), 32'd1);
        check_wr("addu", 0, 32'h3000, 32'h0022_1821);
        check("addu_count", 32'(count), 32'd1);

        // Back-to-back ORI / LW / JAL.
        do_reset();
        send(4'd5, 5'd0, 5'd1, 5'd0, 5'd0, 16'h1234, 26'd0);
        send(4'd6, 5'd0, 5'd2, 5'd0, 5'd0, 16'h0004, 26'd0);
        send(4'd10, 5'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'h000_0C03);
        idle(4);
        check_wr("ori", 0, 32'h3000, 32'h3401_1234);
        check_wr("lw", 1, 32'h3004, 32'h8C02_0004);
        check_wr("jal", 2, 32'h3008, 32'h0C00_0C03);

        // Backpressure: four buffered, the fifth must wait.
        do_reset();
        im_ack = 1'b0;
        for (int i = 0; i < 4; i++) send(4'd1, 5'd0, 5'd0, 5'(i), 5'd0, 16'd0, 26'd0);
        in_valid = 1'b1; in_kind = 4'd1; in_rd = 5'd4;
        for (int i = 0; i < 3; i++) begin
            tick(acc);
            check("hold_accept", 32'(acc), 32'd0);
        end
        check("hold_count", 32'(count), 32'd0);
        im_ack = 1'b1;
        send(4'd1, 5'd0, 5'd0, 5'd4, 5'd0, 16'd0, 26'd0);
        send(4'd1, 5'd0, 5'd0, 5'd5, 5'd0, 16'd0, 26'd0);
        idle(8);
        check("hold_nwr", 32'(wlog.size()), 32'd6);
        check_wr("hold0", 0, 32'h3000, 32'h0000_0021);
        check_wr("hold1", 1, 32'h3004, 32'h0000_0821);
        check_wr("hold2", 2, 32'h3008, 32'h0000_1021);
        check_wr("hold3", 3, 32'h300C, 32'h0000_1821);

        // Illegal kind is swallowed without a write.
        do_reset();
        send(4'd13, 5'd7, 5'd7, 5'd7, 5'd7, 16'hFFFF, 26'h3FF_FFFF);
        send(4'd0, 5'd9, 5'd9, 5'd9, 5'd9, 16'hABCD, 26'h123_4567);
        idle(3);
        check("illegal_flag", 32'(illegal), 32'd1);
        check("illegal_nwr", 32'(wlog.size()), 32'd1);
        check_wr("illegal_nop", 0, 32'h3000, 32'h0);
        check("illegal_count", 32'(count), 32'd1);

        // Reset while words are pending.
        do_reset();
        im_ack = 1'b0;
        send(4'd5, 5'd1, 5'd2, 5'd0, 5'd0, 16'h0001, 26'd0);
        send(4'd7, 5'd3, 5'd4, 5'd0, 5'd0, 16'h0002, 26'd0);
        send(4'd9, 5'd0, 5'd5, 5'd0, 5'd0, 16'h0003, 26'd0);
        idle(1);
        check("rst_pending_we", 32'(im_we), 32'd1);
        do_reset();
        idle(1);
        check("rst_after_we", 32'(im_we), 32'd0);
        check("rst_after_addr", im_addr, 32'h3000);
        im_ack = 1'b1;
        idle(3);
        check("rst_after_nwr", 32'(wlog.size()), 32'd0);
        check("rst_after_count", 32'(count), 32'd0);

        // Random traffic against the reference model.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_kind   = 4'($urandom_range(0, 15));
            in_rs     = 5'($urandom);
            in_rt     = 5'($urandom);
            in_rd     = 5'($urandom);
            in_shamt  = 5'($urandom);
            in_imm    = 16'($urandom);
            in_target = 26'($urandom);
            im_ack    = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 39) == 0);
            reset     = ($urandom_range(0, 99) != 0);
            tick(acc);
        end
        reset = 1'b1; flush = 1'b0; im_ack = 1'b1;
        idle(6);

        // Small image: capacity limit, then flush restarts the image.
        s_reset = 1'b0; s_ack = 1'b1;
        @(posedge clk); #1;
        s_reset = 1'b1; s_valid = 1'b1;
        sacc = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (s_valid && s_ready) sacc++;
            if (s_we && s_ack) swr.push_back(s_addr);
            @(posedge clk); #1;
        end
        check("small_accepts", 32'(sacc), 32'd4);
        check("small_nwr", 32'(swr.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < swr.size()) check("small_addr", swr[i], 32'h3000 + 32'(4 * i));
        end
        @(negedge clk);
        check("small_count", 32'(s_count), 32'd4);
        check("small_full", 32'(s_full), 32'd1);
        check("small_ready_full", 32'(s_ready), 32'd0);
        @(posedge clk); #1;
        s_flush = 1'b1;
        @(negedge clk);
        check("small_ready_flush", 32'(s_ready), 32'd0);
        @(posedge clk); #1;
        s_flush = 1'b0;
        @(negedge clk);
        check("small_flush_count", 32'(s_count), 32'd0);
        check("small_flush_full", 32'(s_full), 32'd0);
        check("small_flush_illegal", 32'(s_illegal), 32'd0);
        check("small_flush_we", 32'(s_we), 32'd0);
        check("small_flush_ready", 32'(s_ready), 32'd1);
        @(posedge clk); #1;
        s_valid = 1'b0;
        @(negedge clk);
        check("small_refill_we", 32'(s_we), 32'd1);
        check("small_refill_addr", s_addr, 32'h3000);
        check("small_refill_data", s_wdata, 32'h0);
        @(posedge clk); #1;
        @(negedge clk);
        check("small_refill_count", 32'(s_count), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instr_image_encoder.md
Name: instr_image_encoder

Overview:
- Encodes symbolic MIPS instruction requests (kind plus fields) into 32-bit machine words and streams them into the instruction-memory write port at consecutive word addresses.
- It is the encoder counterpart of the CPU control decoder and covers the same instruction set.
- It is used by the testbench/boot loader to build program images in IM before the core is released from reset.

Parameters:
- FIFO_DEPTH, 4, entries in the encoded-word buffer; power of two, ≥2.
- IM_AW, 10, IM word-address width; image capacity is 2^IM_AW words.
- BASE_ADDR, 32'h0000_3000, byte address of the first image word.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid & in_ready.
- in_kind  in  4  instruction kind code.
- in_rs, in_rt, in_rd, in_shamt  in  5 each  register and shift fields.
- in_imm  in  16  immediate / branch offset.
- in_target  in  26  jump target field.
- flush  in  1  discard buffered words and restart the image at BASE_ADDR.
- im_we  out  1  IM write request.
- im_addr  out  32  byte address, BASE_ADDR + 4*index.
- im_wdata  out  32  encoded word.
- im_ack  in  1  IM accepts the write when im_we & im_ack.
- count  out  IM_AW+1  words committed to IM.
- full  out  1  count == 2^IM_AW.
- illegal  out  1  sticky: an unsupported kind was received.

Behaviour:
- Reset (reset==0 at an edge): FIFO empties. Outputs: in_ready=0, im_we=0, im_addr=BASE_ADDR, im_wdata=0, count=0, full=0, illegal=0. in_ready may rise in the first cycle after reset deasserts.
- Kind codes and encodings:
  - 0 NOP = 32'h0.
  - 1 ADDU = {6'h00, rs, rt, rd, 5'b0, 6'b100001}.
  - 2 SUBU = same layout, funct 6'b100011.
  - 3 JR = {6'h00, rs, 15'b0, 6'b001000}.
  - 4 SLL = {6'h00, 5'b0, rt, rd, shamt, 6'b000000}.
  - 5 ORI = {6'b001101, rs, rt, imm}.
  - 6 LW = {6'b100011, rs, rt, imm}.
  - 7 SW = {6'b101011, rs, rt, imm}.
  - 8 BEQ = {6'b000100, rs, rt, imm}.
  - 9 LUI = {6'b001111, 5'b0, rt, imm}.
  - 10 JAL = {6'b000011, target}.
  - 11 J = {6'b000010, target}.
  - 12–15: illegal.
- Fields not used by a kind are ignored and forced to zero.
- in_ready = !fifo_full & !flush & (count + fifo_occupancy < 2^IM_AW).
- Accept at edge k, legal kind: the encoded word is pushed into the FIFO at edge k. If the FIFO was empty, im_we=1 with that word during cycle k+1. Latency is 1 cycle.
- Accept, illegal kind: the handshake completes, nothing is pushed, illegal sets at edge k and stays set until reset or flush. count and address are unaffected.
- im_we = FIFO non-empty.
- im_addr / im_wdata present the FIFO head and the current index. They must stay stable while im_we & !im_ack.
- On im_we & im_ack at an edge: pop the head, index += 1, count += 1.
- Push and pop in the same edge are allowed whenever the FIFO is not full; occupancy is unchanged.
- No push at FIFO full, because in_ready is 0 then.
- Words reach IM strictly in acceptance order; no gaps in addresses.
- Capacity: the accept limit counts in-flight FIFO entries, so count never exceeds 2^IM_AW.
  - full=1 exactly when count == 2^IM_AW.
  - The index does not wrap; no further writes occur while full.
- flush (synchronous, priority below reset): FIFO empties, count=0, index=0, full=0, illegal=0. in_ready=0 and im_we is ignored during the flush cycle. im_we=0 in the following cycle.
- Reset mid-write (im_we=1, im_ack pending): the word is dropped and all reset values apply at the next edge.

Decomposition:
- Shared package/header holds:
  - kind codes KIND_NOP..KIND_J;
  - opcode constants ORI, LW, SW, BEQ, LUI, JAL, J;
  - funct constants ADDU, SUBU, JR, SLL.
- These constants are shared with the control decoder so that encoder and decoder cannot diverge.
- Encoding is a pure function inside the block.
- One sub-module: instr_fifo, a synchronous FIFO of width 32 and depth FIFO_DEPTH, with push/pop/full/empty/occupancy outputs and synchronous active-low reset plus clear.

Test Plan:
- Reset, push ADDU rs=1 rt=2 rd=3, im_ack=1 -> im_we=1 with im_addr=0x3000, im_wdata=0x00221821 one cycle after the handshake; count=1.
- Push ORI rs=0 rt=1 imm=0x1234; LW rs=0 rt=2 imm=4; JAL target=0x0000C03 -> writes 0x34011234, 0x8C020004, 0x0C000C03 at 0x3000, 0x3004, 0x3008.
- Hold im_ack=0 and push 6 requests -> exactly 4 accepted then in_ready=0; im_addr/im_wdata stable. Release im_ack -> 4 ordered writes 0x3000..0x300C, then the remaining 2 are accepted.
- Push kind 13, then NOP -> illegal=1, no write for the illegal request; the NOP is written at 0x3000; count=1.
- IM_AW=2, push 5 NOPs -> 4 written, full=1, in_ready=0 with the 5th pending. Pulse flush -> count=0, full=0, illegal=0; the 5th is accepted and written at 0x3000.
- Reset asserted with FIFO holding 3 words and im_we=1 -> next cycle im_we=0, count=0, im_addr=0x3000; no further writes.
